pic_phase_gen: RTL and testbench
================================

# pic_phase_gen

Parametrised instruction-cycle phase generator for the PIC16F84 model. It divides the oscillator clock into PHASES one-hot phase strobes (Q1..Qn) and a CLKOUT-style half-cycle signal. Operation is gated by a supply-valid window, an optional power-up timer, MCLR, and a SLEEP-style stall that halts on a cycle boundary. It sits between the oscillator input and the core sequencer, and replaces the fixed 4-phase generator.

## Interface
- PHASES, 4, phases per instruction cycle; even, ≥2
- DIV, 1, oscillator clocks per phase; ≥1
- VDD_W, 4, width of vdd/vss supply codes
- VDD_MIN, 2, lowest valid vdd code (inclusive)
- VDD_MAX, 6, highest valid vdd code (inclusive)
- PWRT_CYCLES, 8, power-up timer length in clk edges; ≥1
- CNT_W, 16, width of cycle_count
- clk  in  1  oscillator clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- vdd  in  VDD_W  supply code
- vss  in  VDD_W  ground code
- mclr  in  1  active-low master clear
- stall  in  1  request halt at next cycle boundary (SLEEP)
- q  out  PHASES  one-hot phase strobes; q[0] = Q1
- clk_out  out  1  high during the second half of the phases
- cyc_start  out  1  one-clk pulse with the first clk of q[0]
- power_good  out  1  supply valid and power-up complete
- cycle_count  out  CNT_W  instruction cycles started, wrapping

## Operation
- supply_ok = (VDD_MIN ≤ vdd ≤ VDD_MAX) && vss == 0.
- States:
  - OFF, PWRT, RUN, HALT.
  - Internal counters: ph (0..PHASES-1) and dv (0..DIV-1) name the slot issued on the next RUN edge.
- Per-edge priority, highest first: rst → OFF; !supply_ok → OFF; !mclr; state behaviour.
- In OFF, or on any transition into OFF:
  - q, clk_out, cyc_start, power_good and cycle_count are 0.
  - ph, dv and the PWRT counter are 0.
- OFF with supply_ok: go to PWRT (counter 0); outputs stay 0.
- PWRT:
  - If counter == PWRT_CYCLES-1, go to RUN; otherwise increment the counter.
  - Outputs stay 0.
  - The counter advances regardless of mclr.
- mclr low in RUN or HALT:
  - State becomes RUN.
  - ph = dv = 0; q, clk_out, cyc_start and cycle_count are 0.
  - power_good stays 1.
- RUN with mclr high:
  - If ph == 0, dv == 0 and stall is high: go to HALT, outputs 0, no advance.
  - Otherwise issue slot ph:
    - q = 1<<ph.
    - clk_out = (ph ≥ PHASES/2).
    - cyc_start = (ph == 0 && dv == 0); cycle_count increments when cyc_start is set.
    - Advance dv; on dv wrap advance ph; ph wraps to 0.
- HALT:
  - q, clk_out and cyc_start are 0; power_good = 1; cycle_count is held.
  - stall low: issue slot 0 (q[0], cyc_start, count increment) on this same edge, go to RUN.
- stall is ignored mid-cycle. A raised stall always lets the current cycle finish through q[PHASES-1].
- cycle_count wraps from 2^CNT_W-1 to 0.
- All outputs are registered. q is all-zero or exactly one-hot at all times.

## Timing
- Reset values: all outputs 0, state OFF.
- Supply becomes valid at edge E (PWRT enabled):
  - power_good rises after edge E+PWRT_CYCLES.
  - q[0] and the first cyc_start follow at edge E+PWRT_CYCLES+1.
- Each q bit is high for DIV consecutive clks. One instruction cycle is PHASES×DIV clks.
- clk_out is low for (PHASES/2)×DIV clks, then high for (PHASES/2)×DIV clks.
- Supply loss: outputs clear on the first edge that samples !supply_ok. Recovery always repeats the PWRT sequence.
- mclr release: q[0] is issued on the first edge with mclr high. No PWRT re-run.
- Stall wake latency: 1 edge from stall low to q[0].
- rst wins over every simultaneous event.

## Configuration
- PIC_PHASE_GEN_PWRT_EN defined: OFF → PWRT → RUN, as described above.
- Undefined:
  - The PWRT state and counter are absent.
  - OFF with supply_ok goes straight to RUN; power_good rises after edge E.
  - q[0] is issued at E+1.
  - PWRT_CYCLES is ignored.

## Test plan
- Power-up, macro defined: PHASES=4, DIV=2, PWRT_CYCLES=8; rst, then vdd=5, vss=0, mclr=1 from edge E → power_good 1 after E+8; q=0001 after E+9. Macro undefined → power_good after E, q=0001 at E+1.
- Steady run, same config → q sequence 0001,0001,0010,0010,0100,0100,1000,1000 repeating; clk_out 0,0,0,0,1,1,1,1; cyc_start every 8 clks; cycle_count 0→1→2; with CNT_W=2 it wraps 3→0.
- Stall raised during q=0010 → sequence completes through 1000, then q=0, power_good=1, count held. Stall dropped → q=0001 on the next edge, count +1.
- vdd=7 while q=0100 → next edge all outputs 0, power_good 0, count 0. vdd=5 again → full 8-edge PWRT before q=0001. Repeat with vss=1 → same result.
- mclr low while q=0100 → next edge q=0, count 0, power_good 1. mclr high → q=0001 on the first edge.
- rst high in the same edge as stall release and mclr low → state OFF, all outputs 0.

Source files
------------

// File: rtl/pic_phase_gen.sv
// Instruction-cycle phase generator: divides clk into PHASES one-hot strobes plus clk_out.
// Define PIC_PHASE_GEN_PWRT_EN to insert the power-up timer between supply-valid and RUN.
module pic_phase_gen #(
    parameter int PHASES      = 4,
    parameter int DIV         = 1,
    parameter int VDD_W       = 4,
    parameter int VDD_MIN     = 2,
    parameter int VDD_MAX     = 6,
    parameter int PWRT_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VDD_W-1:0]  vdd,
    input  logic [VDD_W-1:0]  vss,
    input  logic              mclr,
    input  logic              stall,
    output logic [PHASES-1:0] q,
    output logic              clk_out,
    output logic              cyc_start,
    output logic              power_good,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int PH_W = $clog2(PHASES);
    localparam int DV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(PHASES / 2);
    localparam logic [DV_W-1:0] DV_LAST = DV_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_PWRT,
        S_RUN,
        S_HALT
    } state_t;

    state_t            state, state_n;
    logic [PH_W-1:0]   ph, ph_n;
    logic [DV_W-1:0]   dv, dv_n;
    logic [PHASES-1:0] q_n;
    logic              clk_out_n;
    logic              cyc_n;
    logic              pg_n;
    logic [CNT_W-1:0]  count_n;
    logic              supply_ok;

`ifdef PIC_PHASE_GEN_PWRT_EN
    localparam int PW_W = (PWRT_CYCLES > 1) ? $clog2(PWRT_CYCLES) : 1;
    localparam logic [PW_W-1:0] PWRT_LAST = PW_W'(PWRT_CYCLES - 1);
    logic [PW_W-1:0] pwrt_cnt, pwrt_n;
`endif

    assign supply_ok = (vdd >= VDD_W'(VDD_MIN)) && (vdd <= VDD_W'(VDD_MAX)) && (vss == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_OFF;
            ph          <= '0;
            dv          <= '0;
            q           <= '0;
            clk_out     <= 1'b0;
            cyc_start   <= 1'b0;
            power_good  <= 1'b0;
            cycle_count <= '0;
`ifdef PIC_PHASE_GEN_PWRT_EN
            pwrt_cnt    <= '0;
`endif
        end else begin
            state       <= state_n;
            ph          <= ph_n;
            dv          <= dv_n;
            q           <= q_n;
            clk_out     <= clk_out_n;
            cyc_start   <= cyc_n;
            power_good  <= pg_n;
            cycle_count <= count_n;
`ifdef PIC_PHASE_GEN_PWRT_EN
            pwrt_cnt    <= pwrt_n;
`endif
        end
    end

    // Outputs are computed one edge ahead so every output is a plain register.
    always_comb begin
        state_n   = state;
        ph_n      = ph;
        dv_n      = dv;
        q_n       = '0;
        clk_out_n = 1'b0;
        cyc_n     = 1'b0;
        pg_n      = power_good;
        count_n   = cycle_count;
`ifdef PIC_PHASE_GEN_PWRT_EN
        pwrt_n    = pwrt_cnt;
`endif
        if (!supply_ok) begin
            state_n = S_OFF;
            ph_n    = '0;
            dv_n    = '0;
            pg_n    = 1'b0;
            count_n = '0;
`ifdef PIC_PHASE_GEN_PWRT_EN
            pwrt_n  = '0;
`endif
        end else begin
            case (state)
                S_OFF: begin
`ifdef PIC_PHASE_GEN_PWRT_EN
                    state_n = S_PWRT;
                    pwrt_n  = '0;
                    pg_n    = 1'b0;
`else
                    state_n = S_RUN;
                    pg_n    = 1'b1;
`endif
                end
                S_PWRT: begin
`ifdef PIC_PHASE_GEN_PWRT_EN
                    if (pwrt_cnt == PWRT_LAST) begin
                        state_n = S_RUN;
                        pwrt_n  = '0;
                        pg_n    = 1'b1;
                    end else begin
                        pwrt_n  = pwrt_cnt + 1'b1;
                    end
`else
                    state_n = S_OFF;
                    pg_n    = 1'b0;
`endif
                end
                default: begin
                    // RUN and HALT share one path: HALT is only ever entered at ph == dv == 0.
                    pg_n = 1'b1;
                    if (!mclr) begin
                        state_n = S_RUN;
                        ph_n    = '0;
                        dv_n    = '0;
                        count_n = '0;
                    end else if (ph == '0 && dv == '0 && stall) begin
                        state_n = S_HALT;
                    end else begin
                        state_n   = S_RUN;
                        q_n       = {{(PHASES-1){1'b0}}, 1'b1} << ph;
                        clk_out_n = (ph >= PH_HALF);
                        cyc_n     = (ph == '0) && (dv == '0);
                        if (cyc_n) begin
                            count_n = cycle_count + CNT_W'(1);
                        end
                        if (dv == DV_LAST) begin
                            dv_n = '0;
                            ph_n = (ph == PH_LAST) ? '0 : ph + 1'b1;
                        end else begin
                            dv_n = dv + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_phase_gen.sv
// Directed bench for pic_phase_gen (PHASES=4, DIV=2, CNT_W=2); expected power-up latency
// follows whether PIC_PHASE_GEN_PWRT_EN is defined.
module tb_pic_phase_gen;

    localparam int PHASES      = 4;
    localparam int DIV         = 2;
    localparam int PWRT_CYCLES = 8;
    localparam int CNT_W       = 2;
`ifdef PIC_PHASE_GEN_PWRT_EN
    localparam int PWRT_LAT = PWRT_CYCLES;
`else
    localparam int PWRT_LAT = 0;
`endif

    logic              clk;
    logic              rst;
    logic [3:0]        vdd;
    logic [3:0]        vss;
    logic              mclr;
    logic              stall;
    logic [PHASES-1:0] q;
    logic              clk_out;
    logic              cyc_start;
    logic              power_good;
    logic [CNT_W-1:0]  cycle_count;

    int n_compared   = 0;
    int n_mismatched = 0;
    int k;
    logic [CNT_W-1:0] exp_cnt;

    pic_phase_gen #(
        .PHASES      (PHASES),
        .DIV         (DIV),
        .VDD_W       (4),
        .VDD_MIN     (2),
        .VDD_MAX     (6),
        .PWRT_CYCLES (PWRT_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vdd         (vdd),
        .vss         (vss),
        .mclr        (mclr),
        .stall       (stall),
        .q           (q),
        .clk_out     (clk_out),
        .cyc_start   (cyc_start),
        .power_good  (power_good),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n RUN edges, checking each against the bench's own slot position model.
    task automatic run_edges(input int n, input string tag);
        logic [3:0] exp_q;
        logic       exp_clk;
        logic       exp_cyc;
        for (int i = 0; i < n; i++) begin
            tick();
            k = (k + 1) % (PHASES * DIV);
            exp_q   = 4'b0001 << (k / DIV);
            exp_clk = ((k / DIV) >= PHASES / 2);
            exp_cyc = (k == 0);
            if (exp_cyc) exp_cnt = exp_cnt + 1'b1;
            n_compared += 4;
            if (q !== exp_q) begin
                n_mismatched++;
                $display("[TB] FAIL %s q k=%0d: got %b expected %b", tag, k, q, exp_q);
            end
            if (clk_out !== exp_clk) begin
                n_mismatched++;
                $display("[TB] FAIL %s clk_out k=%0d: got %b expected %b", tag, k, clk_out, exp_clk);
            end
            if (cyc_start !== exp_cyc) begin
                n_mismatched++;
                $display("[TB] FAIL %s cyc_start k=%0d: got %b expected %b", tag, k, cyc_start, exp_cyc);
            end
            if (cycle_count !== exp_cnt) begin
                n_mismatched++;
                $display("[TB] FAIL %s cycle_count k=%0d: got %0d expected %0d", tag, k, cycle_count, exp_cnt);
            end
        end
    endtask

    // Supply is valid and state is OFF; the next edge is E.
    task automatic run_power_up(input string tag);
        tick();
        n_compared += 3;
        if (power_good !== (PWRT_LAT == 0)) begin
            n_mismatched++;
            $display("[TB] FAIL %s power_good@E: got %b expected %b", tag, power_good, (PWRT_LAT == 0));
        end
        if (q !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL %s q@E: got %b expected 0000", tag, q);
        end
        if (cycle_count !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL %s cycle_count@E: got %0d expected 0", tag, cycle_count);
        end
        for (int i = 1; i <= PWRT_LAT; i++) begin
            tick();
            n_compared += 2;
            if (power_good !== (i == PWRT_LAT)) begin
                n_mismatched++;
                $display("[TB] FAIL %s power_good@E+%0d: got %b expected %b", tag, i, power_good, (i == PWRT_LAT));
            end
            if (q !== 4'b0000) begin
                n_mismatched++;
                $display("[TB] FAIL %s q@E+%0d: got %b expected 0000", tag, i, q);
            end
        end
        tick();
        n_compared += 4;
        if (q !== 4'b0001) begin
            n_mismatched++;
            $display("[TB] FAIL %s first q: got %b expected 0001", tag, q);
        end
        if (cyc_start !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL %s first cyc_start: got %b expected 1", tag, cyc_start);
        end
        if (cycle_count !== 2'd1) begin
            n_mismatched++;
            $display("[TB] FAIL %s first cycle_count: got %0d expected 1", tag, cycle_count);
        end
        if (power_good !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL %s power_good at first q: got %b expected 1", tag, power_good);
        end
        k       = 0;
        exp_cnt = 2'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vdd = 4'd5; vss = 4'd0; mclr = 1'b1; stall = 1'b0;
        tick();
        tick();
        n_compared += 5;
        if (q !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL reset q: got %b expected 0000", q); end
        if (clk_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset clk_out: got %b expected 0", clk_out); end
        if (cyc_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset cyc_start: got %b expected 0", cyc_start); end
        if (power_good !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset power_good: got %b expected 0", power_good); end
        if (cycle_count !== 2'd0) begin n_mismatched++; $display("[TB] FAIL reset cycle_count: got %0d expected 0", cycle_count); end
    endtask

    task automatic test_power_up();
        rst = 1'b0;
        run_power_up("power_up");
    endtask

    task automatic test_steady_run();
        run_edges(31, "steady");
    endtask

    task automatic test_stall();
        run_edges(3, "stall_pre");
        stall = 1'b1;
        run_edges(5, "stall_finish");
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared += 4;
            if (q !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL halt q #%0d: got %b expected 0000", i, q); end
            if (cyc_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL halt cyc_start #%0d: got %b expected 0", i, cyc_start); end
            if (power_good !== 1'b1) begin n_mismatched++; $display("[TB] FAIL halt power_good #%0d: got %b expected 1", i, power_good); end
            if (cycle_count !== exp_cnt) begin n_mismatched++; $display("[TB] FAIL halt cycle_count #%0d: got %0d expected %0d", i, cycle_count, exp_cnt); end
        end
        stall = 1'b0;
        tick();
        exp_cnt = exp_cnt + 1'b1;
        k = 0;
        n_compared += 3;
        if (q !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL wake q: got %b expected 0001", q); end
        if (cyc_start !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wake cyc_start: got %b expected 1", cyc_start); end
        if (cycle_count !== exp_cnt) begin n_mismatched++; $display("[TB] FAIL wake cycle_count: got %0d expected %0d", cycle_count, exp_cnt); end
        run_edges(3, "stall_post");
    endtask

    task automatic test_supply_loss(input logic use_vss);
        run_edges((PHASES * DIV + 4 - k) % (PHASES * DIV), "loss_pre");
        if (use_vss) vss = 4'd1; else vdd = 4'd7;
        tick();
        n_compared += 5;
        if (q !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL loss q vss=%b: got %b expected 0000", use_vss, q); end
        if (clk_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL loss clk_out vss=%b: got %b expected 0", use_vss, clk_out); end
        if (cyc_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL loss cyc_start vss=%b: got %b expected 0", use_vss, cyc_start); end
        if (power_good !== 1'b0) begin n_mismatched++; $display("[TB] FAIL loss power_good vss=%b: got %b expected 0", use_vss, power_good); end
        if (cycle_count !== 2'd0) begin n_mismatched++; $display("[TB] FAIL loss cycle_count vss=%b: got %0d expected 0", use_vss, cycle_count); end
        vdd = 4'd5;
        vss = 4'd0;
        run_power_up(use_vss ? "recover_vss" : "recover_vdd");
    endtask

    task automatic test_mclr();
        run_edges(4, "mclr_pre");
        mclr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_compared += 4;
            if (q !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL mclr q #%0d: got %b expected 0000", i, q); end
            if (cyc_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mclr cyc_start #%0d: got %b expected 0", i, cyc_start); end
            if (power_good !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mclr power_good #%0d: got %b expected 1", i, power_good); end
            if (cycle_count !== 2'd0) begin n_mismatched++; $display("[TB] FAIL mclr cycle_count #%0d: got %0d expected 0", i, cycle_count); end
        end
        mclr = 1'b1;
        tick();
        k = 0;
        exp_cnt = 2'd1;
        n_compared += 3;
        if (q !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL mclr release q: got %b expected 0001", q); end
        if (cyc_start !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mclr release cyc_start: got %b expected 1", cyc_start); end
        if (cycle_count !== 2'd1) begin n_mismatched++; $display("[TB] FAIL mclr release cycle_count: got %0d expected 1", cycle_count); end
        run_edges(3, "mclr_post");
    endtask

    task automatic test_rst_priority();
        stall = 1'b1;
        run_edges(PHASES * DIV - 1 - k, "rst_pre");
        tick();
        n_compared += 1;
        if (q !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL rst_pre halt q: got %b expected 0000", q); end
        stall = 1'b0;
        mclr  = 1'b0;
        rst   = 1'b1;
        tick();
        n_compared += 3;
        if (q !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL rst_prio q: got %b expected 0000", q); end
        if (power_good !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_prio power_good: got %b expected 0", power_good); end
        if (cycle_count !== 2'd0) begin n_mismatched++; $display("[TB] FAIL rst_prio cycle_count: got %0d expected 0", cycle_count); end
        rst  = 1'b0;
        mclr = 1'b1;
        run_power_up("rst_prio_restart");
        run_edges(8, "rst_prio_run");
    endtask

    initial begin
        k = 0;
        exp_cnt = '0;
        test_reset();
        test_power_up();
        test_steady_run();
        test_stall();
        test_supply_loss(1'b0);
        test_supply_loss(1'b1);
        test_mclr();
        test_rst_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
